prog_mem_ctrl: RTL and testbench
================================

# prog_mem_ctrl

Controller that sequences a writable program memory of 2^ADDR_SIZE words × DATA_SIZE bits for the Salamander-4 core. After reset it clears the memory, then accepts a program image over a valid/ready load port and verifies it by read-back XOR checksum. Only then does it release the core, passing instruction fetches to the memory. It sits between the external loader, the program memory array and the core's fetch stage, and is the sole owner of the memory's address and write-enable.

## Interface
- DATA_SIZE, 6, instruction word width
- ADDR_SIZE, 5, program memory address width; depth = 2^ADDR_SIZE
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- LD_START  in  1  request a new load; sampled in IDLE or RUN only
- LD_LEN  in  ADDR_SIZE  word count, sampled with LD_START; 0 means 2^ADDR_SIZE
- LD_VALID  in  1  loader word valid
- LD_DATA  in  DATA_SIZE  loader word
- LD_READY  out  1  controller accepts word
- LD_DONE  out  1  one-cycle pulse on load+verify completion
- LD_ERR  out  1  verify mismatch flag; level, held until next LD_START accepted
- FETCH_ADDR  in  ADDR_SIZE  core program counter
- FETCH_DATA  out  DATA_SIZE  instruction to core
- CPU_STALL  out  1  core must hold PC and not execute
- MEM_ADDR  out  ADDR_SIZE  memory address (write and async read)
- MEM_WE  out  1  memory write enable
- MEM_WDATA  out  DATA_SIZE  memory write data
- MEM_RDATA  in  DATA_SIZE  memory async read data for MEM_ADDR

## Operation
- States: CLEAR, IDLE, LOAD, VERIFY, RUN.
- rst (any state, any time, including mid-load): next state CLEAR, address counter 0, checksums 0, LD_ERR 0. The in-progress load is abandoned.
- CLEAR: MEM_WE=1, MEM_WDATA=0, MEM_ADDR=counter. Counter increments each cycle. After writing address 2^ADDR_SIZE-1 -> IDLE.
- IDLE: waits for LD_START. On LD_START, latch LD_LEN, clear counter and load checksum, clear LD_ERR -> LOAD.
- LOAD: LD_READY=1. On LD_VALID&LD_READY:
  - MEM_WE=1, MEM_ADDR=counter, MEM_WDATA=LD_DATA.
  - load checksum ^= LD_DATA; counter++.
  - After the word at index len-1 is accepted: counter -> 0 and verify checksum -> 0; next state VERIFY.
  - LD_VALID low: no write, no state change.
- VERIFY: MEM_WE=0, MEM_ADDR=counter. Each cycle verify checksum ^= MEM_RDATA and counter++.
  - On the cycle reading index len-1, compare (verify checksum ^ MEM_RDATA) against the load checksum.
  - Equal -> RUN. Unequal -> IDLE with LD_ERR=1.
- RUN: MEM_WE=0, MEM_ADDR=FETCH_ADDR, FETCH_DATA=MEM_RDATA, CPU_STALL=0. LD_START -> LOAD, same as from IDLE.
- LD_START is ignored in CLEAR, LOAD and VERIFY.
- Counter and length arithmetic is ADDR_SIZE+1 bits wide, so len=2^ADDR_SIZE terminates correctly with no wrap aliasing.
- Words beyond len keep their previous contents; they are not cleared on reload.

## Timing
- Reset values: state CLEAR; LD_READY 0, LD_DONE 0, LD_ERR 0, CPU_STALL 1, FETCH_DATA 0, MEM_WE 1, MEM_ADDR 0, MEM_WDATA 0. MEM_WE is 1 because CLEAR begins immediately.
- CLEAR lasts exactly 2^ADDR_SIZE cycles (32 at default). The first IDLE cycle follows.
- CPU_STALL=1 in every state except RUN. FETCH_DATA=0 whenever CPU_STALL=1.
- Fetch path in RUN is combinational: FETCH_ADDR -> MEM_ADDR -> MEM_RDATA -> FETCH_DATA, zero-cycle latency.
- LD_READY depends on state only, never on LD_VALID. A word is transferred in the cycle where both are high.
- LOAD -> VERIFY occurs on the edge after the final handshake.
- VERIFY lasts exactly len cycles.
- LD_DONE=1 for exactly the first cycle of the RUN or IDLE state entered from VERIFY. It fires on both pass and fail.
- LD_ERR is valid in the same cycle as LD_DONE.
- Minimum LD_START-to-RUN latency: 1 + len + len cycles (start edge, len LOAD beats, len VERIFY cycles).

## Test plan
- Reset, then clear: hold rst 2 cycles, release. Required response:
  - MEM_WE=1 for 32 cycles, MEM_ADDR 0..31, MEM_WDATA=0.
  - Then IDLE with CPU_STALL=1 and LD_READY=0.
- Normal load: LD_START with LD_LEN=4, words 0x01,0x02,0x04,0x08 with LD_VALID continuous. Required response:
  - Writes to addresses 0..3.
  - 4 VERIFY cycles, then LD_DONE pulse with LD_ERR=0.
  - In RUN, FETCH_ADDR=2 gives FETCH_DATA=0x04 in the same cycle.
- Backpressure and gaps: LD_LEN=3 with LD_VALID toggling 1,0,0,1,0,1. Required response: exactly 3 writes, to addresses 0,1,2, and no writes in the gap cycles.
- Full depth: LD_LEN=0, 32 words of value i^0x15. Required response:
  - 32 writes, then 32 VERIFY cycles, then LD_DONE.
  - FETCH_ADDR=31 returns 0x0A.
- Verify failure: testbench forces MEM_RDATA bit0 inverted during VERIFY of a 2-word load. Required response:
  - LD_DONE pulses with LD_ERR=1.
  - State IDLE, CPU_STALL=1.
  - A new LD_START clears LD_ERR.
- Reset mid-load: assert rst after 2 of 5 accepted words. Required response:
  - Next cycle enters CLEAR; the full 32-cycle clear follows.
  - No LD_DONE pulse; LD_ERR=0.

Source files
------------

// File: rtl/prog_mem_ctrl.sv
// -----------------------------------------------------------------------------
// prog_mem_ctrl
//   Sequencer for the Salamander-4 writable program memory. After reset it
//   zero-fills the whole array. It then accepts a program image over a
//   valid/ready load port and re-reads the loaded words to compare an XOR
//   checksum. It only releases the core (CPU_STALL=0) once that check passes.
//   This block is the sole owner of the memory address and write enable.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   LD_START, LD_LEN         load request and word count (0 = full depth)
//   LD_VALID, LD_DATA        loader word stream
//   LD_READY                 high for the whole LOAD state
//   LD_DONE                  one-cycle pulse when verify completes
//   LD_ERR                   verify mismatch flag, held until the next load
//   FETCH_ADDR, FETCH_DATA   core fetch path (combinational in RUN)
//   CPU_STALL                core hold request (low only in RUN)
//   MEM_ADDR, MEM_WE,
//   MEM_WDATA, MEM_RDATA     program memory port (async read)
// -----------------------------------------------------------------------------
module prog_mem_ctrl #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 LD_START,
   input  logic [ADDR_SIZE-1:0] LD_LEN,
   input  logic                 LD_VALID,
   input  logic [DATA_SIZE-1:0] LD_DATA,
   output logic                 LD_READY,
   output logic                 LD_DONE,
   output logic                 LD_ERR,
   input  logic [ADDR_SIZE-1:0] FETCH_ADDR,
   output logic [DATA_SIZE-1:0] FETCH_DATA,
   output logic                 CPU_STALL,
   output logic [ADDR_SIZE-1:0] MEM_ADDR,
   output logic                 MEM_WE,
   output logic [DATA_SIZE-1:0] MEM_WDATA,
   input  logic [DATA_SIZE-1:0] MEM_RDATA
);

   // Counter and length carry one extra bit so a full-depth load
   // (length 2^ADDR_SIZE) is representable and terminates without aliasing.
   localparam int CW = ADDR_SIZE + 1;
   localparam logic [CW-1:0] ONE       = {{ADDR_SIZE{1'b0}}, 1'b1};
   localparam logic [CW-1:0] DEPTH     = {1'b1, {ADDR_SIZE{1'b0}}};
   localparam logic [CW-1:0] LAST_ADDR = {1'b0, {ADDR_SIZE{1'b1}}};

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_VERIFY = 3'd3,
      ST_RUN    = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [CW-1:0]        cnt_r;
   logic [CW-1:0]        len_r;
   logic [DATA_SIZE-1:0] ld_sum_r;
   logic [DATA_SIZE-1:0] vf_sum_r;
   logic                 err_r;
   logic                 done_r;

   logic                 accept_s;
   logic                 last_s;
   logic                 match_s;
   logic                 start_s;

   // A word moves only in LOAD with LD_VALID; last_s marks index len-1.
   assign accept_s = (state_r == ST_LOAD) && LD_VALID;
   assign last_s   = (cnt_r == (len_r - ONE));
   // Final verify compare folds in the word read on the last VERIFY cycle.
   assign match_s  = ((vf_sum_r ^ MEM_RDATA) == ld_sum_r);
   assign start_s  = ((state_r == ST_IDLE) || (state_r == ST_RUN)) && LD_START;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_CLEAR;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (cnt_r == LAST_ADDR) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_IDLE, ST_RUN: begin
            if (LD_START) begin
               state_s = ST_LOAD;
            end else begin
               state_s = state_r;
            end
         end
         ST_LOAD: begin
            if (accept_s && last_s) begin
               state_s = ST_VERIFY;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_VERIFY: begin
            if (last_s) begin
               state_s = match_s ? ST_RUN : ST_IDLE;
            end else begin
               state_s = ST_VERIFY;
            end
         end
         default: state_s = ST_CLEAR;
      endcase
   end

   // Address counter, latched length, checksums and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= {CW{1'b0}};
         len_r    <= DEPTH;
         ld_sum_r <= {DATA_SIZE{1'b0}};
         vf_sum_r <= {DATA_SIZE{1'b0}};
         err_r    <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_CLEAR: begin
               if (cnt_r == LAST_ADDR) begin
                  cnt_r <= {CW{1'b0}};
               end else begin
                  cnt_r <= cnt_r + ONE;
               end
            end
            ST_IDLE, ST_RUN: begin
               if (start_s) begin
                  len_r    <= (LD_LEN == {ADDR_SIZE{1'b0}}) ? DEPTH : {1'b0, LD_LEN};
                  cnt_r    <= {CW{1'b0}};
                  ld_sum_r <= {DATA_SIZE{1'b0}};
                  err_r    <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept_s) begin
                  ld_sum_r <= ld_sum_r ^ LD_DATA;
                  if (last_s) begin
                     cnt_r    <= {CW{1'b0}};
                     vf_sum_r <= {DATA_SIZE{1'b0}};
                  end else begin
                     cnt_r <= cnt_r + ONE;
                  end
               end
            end
            ST_VERIFY: begin
               if (last_s) begin
                  cnt_r  <= {CW{1'b0}};
                  done_r <= 1'b1;
                  err_r  <= ~match_s;
               end else begin
                  vf_sum_r <= vf_sum_r ^ MEM_RDATA;
                  cnt_r    <= cnt_r + ONE;
               end
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Memory port and core interface decode; fetch path is combinational in RUN.
   always_comb begin
      MEM_ADDR   = cnt_r[ADDR_SIZE-1:0];
      MEM_WE     = 1'b0;
      MEM_WDATA  = {DATA_SIZE{1'b0}};
      LD_READY   = 1'b0;
      CPU_STALL  = 1'b1;
      FETCH_DATA = {DATA_SIZE{1'b0}};
      case (state_r)
         ST_CLEAR: begin
            MEM_WE = 1'b1;
         end
         ST_LOAD: begin
            LD_READY  = 1'b1;
            MEM_WE    = LD_VALID;
            MEM_WDATA = LD_DATA;
         end
         ST_RUN: begin
            MEM_ADDR   = FETCH_ADDR;
            CPU_STALL  = 1'b0;
            FETCH_DATA = MEM_RDATA;
         end
         default: begin
            MEM_WE = 1'b0;
         end
      endcase
   end

   assign LD_DONE = done_r;
   assign LD_ERR  = err_r;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_ctrl
//   Self-checking bench for prog_mem_ctrl. It provides a behavioural program
//   memory and keeps a reference image of what that memory should hold. Loads
//   use randomized data, lengths and valid gaps. Expected verify outcomes come
//   from XOR sums over the reference image.
// -----------------------------------------------------------------------------
module tb_prog_mem_ctrl;

   localparam int DW    = 6;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_start;
   logic [AW-1:0] ld_len;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          ld_done;
   logic          ld_err;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] fetch_data;
   logic          cpu_stall;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] arr      [DEPTH];   // the memory the controller drives
   logic [DW-1:0] ref_mem  [DEPTH];   // what that memory should contain
   logic [DW-1:0] ld_words [DEPTH];   // image for the next load
   bit            corrupt_en;
   logic          corrupt_s;

   always #5 clk = ~clk;

   prog_mem_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .LD_START   (ld_start),
      .LD_LEN     (ld_len),
      .LD_VALID   (ld_valid),
      .LD_DATA    (ld_data),
      .LD_READY   (ld_ready),
      .LD_DONE    (ld_done),
      .LD_ERR     (ld_err),
      .FETCH_ADDR (fetch_addr),
      .FETCH_DATA (fetch_data),
      .CPU_STALL  (cpu_stall),
      .MEM_ADDR   (mem_addr),
      .MEM_WE     (mem_we),
      .MEM_WDATA  (mem_wdata),
      .MEM_RDATA  (mem_rdata)
   );

   // Behavioural program memory: synchronous write, asynchronous read.
   always @(posedge clk) begin
      if (mem_we) arr[mem_addr] <= mem_wdata;
   end

   // Read-path fault injection flips bit 0 of a single verify read (address 1).
   assign corrupt_s = corrupt_en && !mem_we && cpu_stall && (mem_addr == 5'd1);
   assign mem_rdata = arr[mem_addr] ^ {5'b00000, corrupt_s};

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Hold reset for 'hold' edges, then check the full zero-fill sweep.
   task automatic run_reset(input int hold);
      rst      = 1'b1;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      repeat (hold) @(negedge clk);
      #1;
      chk_eq("rst_stall", cpu_stall, 1'b1);
      chk_eq("rst_ready", ld_ready, 1'b0);
      chk_eq("rst_done", ld_done, 1'b0);
      chk_eq("rst_err", ld_err, 1'b0);
      chk_eq("rst_fetch", fetch_data, 6'h00);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         chk_eq("clr_we", mem_we, 1'b1);
         chk_eq("clr_addr", mem_addr, i);
         chk_eq("clr_wdata", mem_wdata, 6'h00);
         chk_eq("clr_done", ld_done, 1'b0);
         chk_eq("clr_err", ld_err, 1'b0);
         @(negedge clk);
      end
      #1;
      chk_eq("idle_we", mem_we, 1'b0);
      chk_eq("idle_stall", cpu_stall, 1'b1);
      chk_eq("idle_ready", ld_ready, 1'b0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 6'h00;
   endtask

   // Load ld_words[0..n-1]. gap_mode 0: continuous valid, 1: pattern 1,0,0,1,0,1,
   // 2: random valid plus random (ignored) LD_START/LD_LEN during LOAD.
   // stop_after >= 0 returns after that many accepted words (for a reset mid-load).
   task automatic do_load(input int len_in, input int gap_mode, input bit corrupt, input int stop_after);
      int n;
      int idx;
      int cyc;
      bit v;
      bit exp_err;
      logic [DW-1:0] ld_x;
      logic [DW-1:0] vf_x;
      logic [5:0] pat;
      pat = 6'b101001;
      n   = (len_in == 0) ? DEPTH : len_in;
      ld_start = 1'b1;
      ld_len   = AW'(len_in);
      #1;
      chk_eq("start_ready", ld_ready, 1'b0);
      @(negedge clk);
      ld_start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 400) begin
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (cyc < 6) ? pat[cyc] : 1'b1;
            default: v = 1'($urandom_range(0, 1));
         endcase
         ld_valid = v;
         ld_data  = ld_words[idx];
         if (gap_mode == 2) begin
            ld_start = 1'($urandom_range(0, 1));
            ld_len   = AW'($urandom);
         end
         #1;
         chk_eq("load_ready", ld_ready, 1'b1);
         chk_eq("load_stall", cpu_stall, 1'b1);
         chk_eq("load_err", ld_err, 1'b0);
         chk_eq("load_we", mem_we, v);
         if (v) begin
            chk_eq("load_addr", mem_addr, idx);
            chk_eq("load_wdata", mem_wdata, ld_words[idx]);
         end
         @(negedge clk);
         if (v) begin
            ref_mem[idx] = ld_words[idx];
            idx++;
         end
         cyc++;
         if (stop_after >= 0 && idx == stop_after) return;
      end
      ld_valid = 1'b0;
      ld_start = 1'b0;
      if (idx < n) begin
         chk_eq("load_timeout", idx, n);
         return;
      end
      ld_x = '0;
      vf_x = '0;
      for (int i = 0; i < n; i++) begin
         ld_x = ld_x ^ ld_words[i];
         vf_x = vf_x ^ ref_mem[i];
      end
      if (corrupt && n > 1) vf_x = vf_x ^ 6'h01;
      exp_err    = (ld_x != vf_x);
      corrupt_en = corrupt;
      for (int k = 0; k < n; k++) begin
         #1;
         chk_eq("vfy_we", mem_we, 1'b0);
         chk_eq("vfy_addr", mem_addr, k);
         chk_eq("vfy_ready", ld_ready, 1'b0);
         chk_eq("vfy_fetch", fetch_data, 6'h00);
         chk_eq("vfy_done", ld_done, 1'b0);
         @(negedge clk);
      end
      corrupt_en = 1'b0;
      #1;
      chk_eq("done_pulse", ld_done, 1'b1);
      chk_eq("done_err", ld_err, exp_err);
      chk_eq("done_stall", cpu_stall, exp_err);
      @(negedge clk);
      #1;
      chk_eq("done_once", ld_done, 1'b0);
      chk_eq("err_hold", ld_err, exp_err);
   endtask

   // Drive one fetch address and check the same-cycle fetch response.
   task automatic check_fetch(input int a, input bit exp_run);
      fetch_addr = AW'(a);
      #1;
      chk_eq("fetch_stall", cpu_stall, !exp_run);
      chk_eq("fetch_data", fetch_data, exp_run ? ref_mem[a] : 6'h00);
      if (exp_run) chk_eq("fetch_addr", mem_addr, a);
      @(negedge clk);
   endtask

   initial begin
      int len;
      rst        = 1'b1;
      ld_start   = 1'b0;
      ld_len     = '0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      fetch_addr = '0;
      corrupt_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) arr[i] = DW'($urandom);

      run_reset(2);

      // Normal 4-word load.
      ld_words[0] = 6'h01; ld_words[1] = 6'h02; ld_words[2] = 6'h04; ld_words[3] = 6'h08;
      do_load(4, 0, 1'b0, -1);
      fetch_addr = 5'd2;
      #1;
      chk_eq("fetch2_const", fetch_data, 6'h04);
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_fetch($urandom_range(0, DEPTH - 1), 1'b1);

      // Backpressure: 3 words with gaps; word 3 must keep its earlier value.
      for (int i = 0; i < 3; i++) ld_words[i] = DW'($urandom);
      do_load(3, 1, 1'b0, -1);
      for (int i = 0; i < 5; i++) check_fetch(i, 1'b1);

      // Full depth via LD_LEN=0.
      for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'(i ^ 21);
      do_load(0, 0, 1'b0, -1);
      fetch_addr = 5'd31;
      #1;
      chk_eq("fetch31_const", fetch_data, 6'h0A);
      @(negedge clk);
      check_fetch(0, 1'b1);

      // Verify failure on a 2-word load.
      ld_words[0] = DW'($urandom);
      ld_words[1] = DW'($urandom);
      do_load(2, 0, 1'b1, -1);
      check_fetch(3, 1'b0);

      // Randomized loads from IDLE/RUN with random gaps and stray LD_START.
      for (int t = 0; t < 5; t++) begin
         len = $urandom_range(0, DEPTH - 1);
         for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'($urandom);
         do_load(len, 2, 1'b0, -1);
         for (int j = 0; j < 3; j++) check_fetch($urandom_range(0, DEPTH - 1), 1'b1);
      end

      // Reset after 2 of 5 accepted words.
      for (int i = 0; i < 5; i++) ld_words[i] = DW'($urandom);
      do_load(5, 0, 1'b0, 2);
      run_reset(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
